// File: rtl/mem_access.sv
// MEM-stage load/store unit: req/gnt/rvalid bus master with sizing, lane steering, sign-extension, timeout; MEM_ALIGN_CHECK_EN enables misalignment abort.
// Latency: store 3 cycles (stall 2), load 4 cycles (stall 3) minimum; timeout aborts after TIMEOUT_CYCLES in REQ+WAIT.
// Backpressure: dmem_req held until dmem_gnt; pipeline stall held until the access completes or aborts.
module mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_mem_rd,
    input  logic        mem_mem_wr,
    input  logic [1:0]  mem_size,
    input  logic        mem_sign,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_mem_data,
    output logic        stall,
    output logic        bus_err,
    output logic        align_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  lo_q, lo_d;
    logic        sign_q, sign_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [3:0]  dmem_be_q, dmem_be_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [31:0] mem_mem_data_q, mem_mem_data_d;
    logic        bus_err_q, bus_err_d;
    logic        align_err_q, align_err_d;

    logic        start;
    logic        misalign;
    logic        timeout;
    logic [1:0]  req_lo;
    logic [31:0] rd_shift;
    logic [15:0] rd_half;
    logic [31:0] ld_val;

    assign start   = mem_mem_rd | mem_mem_wr;
    assign timeout = (cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_comb begin
        misalign = 1'b0;
        req_lo   = mem_alu_result[1:0];
`ifdef MEM_ALIGN_CHECK_EN
        misalign = ((mem_size == 2'd1) && mem_alu_result[0]) ||
                   (mem_size[1] && (mem_alu_result[1:0] != 2'b00));
`else
        // Without the check, low address bits are dropped to the natural boundary.
        if (mem_size[1])
            req_lo = 2'b00;
        else if (mem_size == 2'd1)
            req_lo = {mem_alu_result[1], 1'b0};
`endif
    end

    always_comb begin
        rd_shift = dmem_rdata >> {lo_q, 3'b000};
        rd_half  = lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (size_q)
            2'd0:    ld_val = {{24{sign_q & rd_shift[7]}}, rd_shift[7:0]};
            2'd1:    ld_val = {{16{sign_q & rd_half[15]}}, rd_half};
            default: ld_val = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        size_d         = size_q;
        lo_d           = lo_q;
        sign_d         = sign_q;
        dmem_req_d     = 1'b0;
        dmem_we_d      = dmem_we_q;
        dmem_be_d      = dmem_be_q;
        dmem_addr_d    = dmem_addr_q;
        dmem_wdata_d   = dmem_wdata_q;
        mem_mem_data_d = mem_mem_data_q;
        bus_err_d      = 1'b0;
        align_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d       = 16'd0;
                    size_d      = mem_size;
                    lo_d        = req_lo;
                    sign_d      = mem_sign;
                    dmem_we_d   = mem_mem_wr;
                    dmem_addr_d = {mem_alu_result[31:2], 2'b00};
                    case (mem_size)
                        2'd0: begin
                            dmem_be_d    = 4'b0001 << req_lo;
                            dmem_wdata_d = {4{mem_wdata[7:0]}};
                        end
                        2'd1: begin
                            dmem_be_d    = req_lo[1] ? 4'b1100 : 4'b0011;
                            dmem_wdata_d = {2{mem_wdata[15:0]}};
                        end
                        default: begin
                            dmem_be_d    = 4'b1111;
                            dmem_wdata_d = mem_wdata;
                        end
                    endcase
                    if (misalign) begin
                        state_d     = DONE;
                        align_err_d = 1'b1;
                        if (!mem_mem_wr)
                            mem_mem_data_d = 32'd0;
                    end else begin
                        state_d    = REQ;
                        dmem_req_d = 1'b1;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 16'd1;
                if (dmem_gnt) begin
                    state_d = dmem_we_q ? DONE : WAIT;
                end else if (timeout) begin
                    state_d   = DONE;
                    bus_err_d = 1'b1;
                    if (!dmem_we_q)
                        mem_mem_data_d = 32'd0;
                end else begin
                    dmem_req_d = 1'b1;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (dmem_rvalid) begin
                    state_d        = DONE;
                    mem_mem_data_d = ld_val;
                end else if (timeout) begin
                    state_d        = DONE;
                    bus_err_d      = 1'b1;
                    mem_mem_data_d = 32'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= 16'd0;
            size_q         <= 2'd0;
            lo_q           <= 2'd0;
            sign_q         <= 1'b0;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_be_q      <= 4'd0;
            dmem_addr_q    <= 32'd0;
            dmem_wdata_q   <= 32'd0;
            mem_mem_data_q <= 32'd0;
            bus_err_q      <= 1'b0;
            align_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            size_q         <= size_d;
            lo_q           <= lo_d;
            sign_q         <= sign_d;
            dmem_req_q     <= dmem_req_d;
            dmem_we_q      <= dmem_we_d;
            dmem_be_q      <= dmem_be_d;
            dmem_addr_q    <= dmem_addr_d;
            dmem_wdata_q   <= dmem_wdata_d;
            mem_mem_data_q <= mem_mem_data_d;
            bus_err_q      <= bus_err_d;
            align_err_q    <= align_err_d;
        end
    end

    // The pipeline must freeze in the very cycle the request is first seen.
    assign stall        = ((state_q == IDLE) && start) || (state_q == REQ) || (state_q == WAIT);
    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign dmem_be      = dmem_be_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign mem_mem_data = mem_mem_data_q;
    assign bus_err      = bus_err_q;
    assign align_err    = align_err_q;
endmodule
